// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks in-flight GPR writes between issue (ID->EX handoff) and the
//   register-file write in WB. Each GPR has a small pending-writer counter:
//   it goes up when a writing instruction issues and down when WB commits
//   the write. ID uses rj_busy/rk_busy to stall RAW hazards that forwarding
//   cannot cover.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   issue_valid/we/dest      instruction handed from ID to EX this cycle
//   issue_ready              dest counter not saturated (r0 always ready)
//   retire_valid/dest        WB register-file write (rf_we / rf_waddr)
//   flush                    discard all pending-writer state
//   query_rj/rk              ID source operands
//   rj_busy/rk_busy          source has >=1 pending writer (registered state)
//   any_busy                 some GPR has a pending writer
//   underflow                sticky: retire seen on a zero counter
module reg_scoreboard #(
  parameter  int NREG  = 32,
  parameter  int CNT_W = 2,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [IDX_W-1:0] issue_dest,
  output logic             issue_ready,
  input  logic             retire_valid,
  input  logic [IDX_W-1:0] retire_dest,
  input  logic             flush,
  input  logic [IDX_W-1:0] query_rj,
  input  logic [IDX_W-1:0] query_rk,
  output logic             rj_busy,
  output logic             rk_busy,
  output logic             any_busy,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             flush_d;
  logic             inc;
  logic             dec;
  logic             same_reg;
  logic             uf_set;

  // Indices at or above NREG address no register; they only exist when
  // NREG is not a power of two.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NREG;
  endfunction

  function automatic logic busy_of(input logic [IDX_W-1:0] idx,
                                   input logic [CNT_W-1:0] c);
    return in_range(idx) && (idx != '0) && (c != '0);
  endfunction

  // A same-cycle retire to a saturated register deliberately does not
  // raise issue_ready; that keeps ready off the WB timing path.
  assign issue_ready = (issue_dest == '0) || !in_range(issue_dest) ||
                       (cnt[issue_dest] != CNT_MAX);

  assign inc = issue_valid && issue_we && issue_ready &&
               (issue_dest != '0) && in_range(issue_dest);
  assign dec = retire_valid && (retire_dest != '0) && in_range(retire_dest);
  assign same_reg = inc && dec && (issue_dest == retire_dest);

  // Retires right after a flush may target writers that the flush already
  // discarded, so the underflow check is masked for that one cycle.
  assign uf_set = dec && !same_reg && !flush && !flush_d &&
                  (cnt[retire_dest] == '0);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (i != 0 && !same_reg) begin
        if (inc && int'(issue_dest) == i)
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        if (dec && int'(retire_dest) == i && cnt[i] != '0)
          cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      underflow <= 1'b0;
      flush_d   <= 1'b0;
    end else begin
      flush_d <= flush;
      for (int i = 0; i < NREG; i++) cnt[i] <= flush ? '0 : cnt_nxt[i];
      if (uf_set) underflow <= 1'b1;
    end
  end

  // Queries see registered state only; WB forwarding covers the retire cycle.
  assign rj_busy = busy_of(query_rj, cnt[query_rj]);
  assign rk_busy = busy_of(query_rk, cnt[query_rk]);

  always_comb begin
    any_busy = 1'b0;
    for (int i = 1; i < NREG; i++) any_busy = any_busy || (cnt[i] != '0);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_we;
  logic [4:0] issue_dest;
  logic       issue_ready;
  logic       retire_valid;
  logic [4:0] retire_dest;
  logic       flush;
  logic [4:0] query_rj;
  logic [4:0] query_rk;
  logic       rj_busy;
  logic       rk_busy;
  logic       any_busy;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .retire_valid (retire_valid),
    .retire_dest  (retire_dest),
    .flush        (flush),
    .query_rj     (query_rj),
    .query_rk     (query_rk),
    .rj_busy      (rj_busy),
    .rk_busy      (rk_busy),
    .any_busy     (any_busy),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_we     = 1'b0;
    retire_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] d);
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_dest  = d;
  endtask

  task automatic do_retire(input logic [4:0] d);
    retire_valid = 1'b1;
    retire_dest  = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    issue_dest  = '0;
    retire_dest = '0;
    query_rj    = 5'd5;
    query_rk    = 5'd7;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_rj_busy", rj_busy, 1'b0);
    chk("rst_rk_busy", rk_busy, 1'b0);
    chk("rst_any_busy", any_busy, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    issue_dest = 5'd7;
    chk("rst_issue_ready", issue_ready, 1'b1);

    // 1: issue r5, visible next cycle; retire not bypassed
    do_issue(5'd5);
    chk("t1_issue_not_visible", rj_busy, 1'b0);
    tick();
    idle();
    chk("t1_rj_busy", rj_busy, 1'b1);
    chk("t1_any_busy", any_busy, 1'b1);
    do_retire(5'd5);
    chk("t1_retire_no_bypass", rj_busy, 1'b1);
    tick();
    idle();
    chk("t1_rj_clear", rj_busy, 1'b0);
    chk("t1_any_clear", any_busy, 1'b0);

    // 2: saturate r7 at 3
    for (int i = 0; i < 3; i++) begin
      do_issue(5'd7);
      chk("t2_ready_before_sat", issue_ready, 1'b1);
      tick();
    end
    idle();
    issue_dest = 5'd7;
    chk("t2_sat_not_ready", issue_ready, 1'b0);
    chk("t2_rk_busy", rk_busy, 1'b1);
    // blocked 4th issue together with a retire: ready stays low, count 3->2
    do_issue(5'd7);
    do_retire(5'd7);
    chk("t2_retire_no_ready_bypass", issue_ready, 1'b0);
    tick();
    idle();
    chk("t2_ready_after_retire", issue_ready, 1'b1);
    chk("t2_busy_after_1st", rk_busy, 1'b1);
    do_retire(5'd7);
    tick();
    idle();
    chk("t2_busy_after_2nd", rk_busy, 1'b1);
    do_retire(5'd7);
    tick();
    idle();
    chk("t2_busy_after_3rd", rk_busy, 1'b0);
    chk("t2_any_clear", any_busy, 1'b0);
    chk("t2_no_underflow", underflow, 1'b0);

    // 3: same-cycle issue/retire
    query_rj = 5'd9;
    query_rk = 5'd3;
    do_issue(5'd9);
    tick();
    do_issue(5'd9);
    do_retire(5'd9);
    tick();
    idle();
    chk("t3_same_reg_held", rj_busy, 1'b1);
    do_issue(5'd3);
    do_retire(5'd9);
    tick();
    idle();
    chk("t3_r9_cleared", rj_busy, 1'b0);
    chk("t3_r3_set", rk_busy, 1'b1);
    do_retire(5'd3);
    tick();
    idle();
    chk("t3_any_clear", any_busy, 1'b0);
    chk("t3_no_underflow", underflow, 1'b0);

    // 4: r0 never tracked
    query_rj = 5'd0;
    query_rk = 5'd0;
    for (int i = 0; i < 4; i++) begin
      do_issue(5'd0);
      do_retire(5'd0);
      chk("t4_r0_ready", issue_ready, 1'b1);
      tick();
    end
    idle();
    chk("t4_rj_r0", rj_busy, 1'b0);
    chk("t4_rk_r0", rk_busy, 1'b0);
    chk("t4_any", any_busy, 1'b0);
    chk("t4_underflow", underflow, 1'b0);

    // 5: flush with masked underflow window
    query_rj = 5'd6;
    query_rk = 5'd10;
    do_issue(5'd4);
    tick();
    do_issue(5'd6);
    tick();
    idle();
    chk("t5_pre_flush_busy", rj_busy, 1'b1);
    flush = 1'b1;
    do_retire(5'd4);
    do_issue(5'd10);
    tick();
    idle();
    chk("t5_flush_any", any_busy, 1'b0);
    chk("t5_flush_rj", rj_busy, 1'b0);
    chk("t5_issue_ignored", rk_busy, 1'b0);
    do_retire(5'd6);
    tick();
    idle();
    chk("t5_masked_underflow", underflow, 1'b0);
    do_retire(5'd6);
    tick();
    idle();
    chk("t5_late_underflow", underflow, 1'b1);
    tick();
    chk("t5_underflow_sticky", underflow, 1'b1);

    // 6: reset wins over a same-cycle issue
    query_rj = 5'd12;
    do_issue(5'd12);
    tick();
    do_issue(5'd12);
    tick();
    chk("t6_busy_before_reset", rj_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    issue_dest = 5'd12;
    chk("t6_rj_after_reset", rj_busy, 1'b0);
    chk("t6_any_after_reset", any_busy, 1'b0);
    chk("t6_ready_after_reset", issue_ready, 1'b1);
    chk("t6_underflow_after_reset", underflow, 1'b0);

    // plain underflow, no flush nearby
    tick();
    do_retire(5'd20);
    tick();
    idle();
    chk("uf_plain", underflow, 1'b1);
    chk("uf_any", any_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
